// File: rtl/std_ram_pkg.sv
// Shared helpers for the single-port RAM wrappers: address-width function,
// wrapper FSM state encoding and byte-lane to bit-mask expansion.
package std_ram_pkg;

    // Widest word the lane-mask helper supports.
    localparam int MAX_DATA_W = 1024;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Address bits needed for n entries; never less than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic [MAX_DATA_W-1:0] expand_be(
        input logic [MAX_DATA_W-1:0] be,
        input int                    byte_w
    );
        logic [MAX_DATA_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_DATA_W; i++) begin
            mask[i] = be[i / byte_w];
        end
        return mask;
    endfunction

endpackage

// File: rtl/std_spram_be_core.sv
// Behavioural single-port array with a registered read and bit-masked write.
// Swap this body for a vendor macro instance when targeting silicon.
module std_spram_be_core #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 128,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] wmask,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range;

    // One spare bit so DEPTH itself is representable when it is a power of two.
    assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (en && we && in_range) begin
            mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
        end
        if (en && !we) begin
            rdata <= in_range ? mem[addr] : '0;
        end
    end

endmodule

// File: rtl/std_spram_pipe_be.sv
// Byte-masked single-port SRAM wrapper: valid/ready requests, optional zero-fill
// after reset, and a show-ahead response FIFO sized so stalled reads are never lost.
module std_spram_pipe_be
    import std_ram_pkg::*;
#(
    parameter int DEPTH     = 256,
    parameter int DATA_W    = 128,
    parameter int BYTE_W    = 8,
    parameter int OUT_REG   = 1,
    parameter int INIT_ZERO = 1,
    localparam int BE_W     = DATA_W / BYTE_W,
    localparam int ADDR_W   = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done
);

    localparam int L         = 1 + OUT_REG;
    localparam int RSP_DEPTH = L + 1;
    localparam int PTR_W     = clog2(RSP_DEPTH);
    localparam int CNT_W     = clog2(RSP_DEPTH + 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    state_t              state;
    state_t              state_next;
    logic                in_init;
    logic                run;
    logic                init_last;
    logic [ADDR_W-1:0]   init_addr;
    logic [CNT_W-1:0]    cnt;
    logic                accept;
    logic                rd_accept;
    logic                pop;

    logic                core_en;
    logic                core_we;
    logic [ADDR_W-1:0]   core_addr;
    logic [DATA_W-1:0]   core_wdata;
    logic [DATA_W-1:0]   core_mask;
    logic [DATA_W-1:0]   core_rdata;

    logic                rd_v1;
    logic                stage_v;
    logic [DATA_W-1:0]   stage_d;

    logic [DATA_W-1:0]   fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fcnt;
    logic                fifo_empty;
    logic                push;
    logic                fifo_pop;
    logic [DATA_W-1:0]   head;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    assign init_last = (init_addr == ADDR_W'(DEPTH - 1));

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (init_last) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    // Handshakes: a request moves when req_valid && req_ready, a response when
    // rsp_valid && rsp_ready. req_ready is built from registered state only, and
    // rsp_valid/rsp_rdata hold steady until the response is taken.
    always_comb begin
        in_init   = (state == ST_INIT);
        run       = !rst && (state == ST_RUN);
        init_done = run;
        req_ready = run && (cnt < CNT_W'(RSP_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_addr <= '0;
        end else if (in_init && !init_last) begin
            init_addr <= init_addr + ADDR_W'(1);
        end
    end

    // ---------------- request path ----------------
    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !req_we;

    always_comb begin
        core_en    = !rst && (in_init || accept);
        core_we    = in_init || req_we;
        core_addr  = in_init ? init_addr : req_addr;
        core_wdata = in_init ? '0 : req_wdata;
        core_mask  = in_init ? '1 : DATA_W'(expand_be(MAX_DATA_W'(req_be), BYTE_W));
    end

    std_spram_be_core #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (clk),
        .en    (core_en),
        .we    (core_we),
        .addr  (core_addr),
        .wdata (core_wdata),
        .wmask (core_mask),
        .rdata (core_rdata)
    );

    // ---------------- read pipeline ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_v1 <= 1'b0;
        end else begin
            rd_v1 <= rd_accept;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_v <= 1'b0;
                    stage_d <= '0;
                end else begin
                    stage_v <= rd_v1;
                    stage_d <= core_rdata;
                end
            end
        end else begin : g_no_oreg
            assign stage_v = rd_v1;
            assign stage_d = core_rdata;
        end
    endgenerate

    // ---------------- response FIFO ----------------
    // An empty FIFO is bypassed so the pipeline head reaches the port in cycle
    // T+L; an unconsumed bypassed word is captured so it stays stable.
    always_comb begin
        fifo_empty = (fcnt == '0);
        head       = fifo_empty ? stage_d : fifo_mem[rd_ptr];
        rsp_valid  = !rst && (!fifo_empty || stage_v);
        rsp_rdata  = rsp_valid ? head : '0;
        pop        = rsp_valid && rsp_ready;
        push       = stage_v && !(fifo_empty && rsp_ready);
        fifo_pop   = pop && !fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem[wr_ptr] <= stage_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (fifo_pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !fifo_pop) begin
                fcnt <= fcnt + CNT_W'(1);
            end else if (!push && fifo_pop) begin
                fcnt <= fcnt - CNT_W'(1);
            end
        end
    end

    // Outstanding reads (in the pipeline or the FIFO); bounds FIFO occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (rd_accept && !pop) begin
            cnt <= cnt + CNT_W'(1);
        end else if (!rd_accept && pop) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule
